fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the instruction cache.
- Owns the program counter and drives the cache address. Captures the instruction the cache returns combinationally in the same cycle.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Applies branch/jump redirects, which flush the FIFO and load a new PC.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures cache data into a small FIFO,
// and hands {pc, instr} pairs to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  output logic [31:0] retired_cnt_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Misaligned redirect targets are truncated to a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return target & ~32'h3;
  endfunction

  logic [31:0]      pc_p0;
  logic [31:0]      pc_buf_p1    [BUF_DEPTH];
  logic [31:0]      instr_buf_p1 [BUF_DEPTH];
  logic [PTR_W-1:0] rd_p1;
  logic [PTR_W-1:0] wr_p1;
  logic [CNT_W-1:0] count_p1;
  logic [31:0]      retired_p1;
  logic             vld_p1;
  logic             pop;
  logic             push;

  assign vld_p1 = (count_p1 != '0);
  assign pop    = vld_p1 & dec_ready_i & ~redirect_i;
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign push   = ~redirect_i & ((count_p1 != FULL) | pop);

  // ---- stage p0: program counter and FIFO control ----
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_p0      <= RESET_PC;
      count_p1   <= '0;
      rd_p1      <= '0;
      wr_p1      <= '0;
      retired_p1 <= '0;
    end else if (redirect_i) begin
      pc_p0    <= align_pc(redirect_pc_i);
      count_p1 <= '0;
      rd_p1    <= '0;
      wr_p1    <= '0;
    end else begin
      if (push) begin
        pc_p0 <= next_pc(pc_p0);
        wr_p1 <= wr_p1 + PTR_W'(1);
      end
      if (pop) begin
        rd_p1      <= rd_p1 + PTR_W'(1);
        retired_p1 <= retired_p1 + 32'd1;
      end
      if (push && !pop) begin
        count_p1 <= count_p1 + CNT_W'(1);
      end else if (pop && !push) begin
        count_p1 <= count_p1 - CNT_W'(1);
      end
    end
  end

  // ---- stage p1: FIFO storage (data only, no reset needed) ----
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_buf_p1[wr_p1]    <= pc_p0;
      instr_buf_p1[wr_p1] <= instr_i;
    end
  end

  assign pc_o          = pc_p0;
  assign dec_valid_o   = vld_p1;
  assign dec_instr_o   = vld_p1 ? instr_buf_p1[rd_p1] : 32'h0;
  assign dec_pc_o      = vld_p1 ? pc_buf_p1[rd_p1] : 32'h0;
  assign retired_cnt_o = retired_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue of expected {pc, instr}
// handshakes, drained by a monitor, plus direct checks of port state.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dvalid;
  logic        dready;
  logic [31:0] dinstr;
  logic [31:0] dpc;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb [$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pc_o(pc),
    .instr_i(instr),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .dec_valid_o(dvalid),
    .dec_ready_i(dready),
    .dec_instr_o(dinstr),
    .dec_pc_o(dpc),
    .retired_cnt_o(retired)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h2000_0537;
      32'h04:  return 32'h0a54_8493;
      32'h08:  return 32'h0010_0093;
      32'h0C:  return 32'h0020_8113;
      32'h10:  return 32'h0031_0193;
      32'h14:  return 32'h0041_8213;
      32'h18:  return 32'h0052_0293;
      32'h1C:  return 32'h0085_2083;
      default: return a ^ 32'hC3A5_0013;
    endcase
  endfunction

  assign instr = imem(pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_hs(input logic [31:0] a, input logic [31:0] i);
    sb.push_back({a, i});
  endtask

  // Monitor: every accepted handshake must match the next expected pair.
  always @(negedge clk) begin
    if (rst && dvalid && dready && !redirect) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_handshake actual=%h/%h required=none", dpc, dinstr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({dpc, dinstr} !== e) begin
          failures++;
          $display("FAIL handshake actual=%h/%h required=%h/%h", dpc, dinstr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; dready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, dvalid}, 32'h0);
    chk("rst_instr", dinstr, 32'h0);
    chk("rst_dpc", dpc, 32'h0);
    chk("rst_retired", retired, 32'h0);

    // Streaming with ready held high: eight handshakes.
    rst = 1'b1; dready = 1'b1;
    expect_hs(32'h00, 32'h2000_0537); expect_hs(32'h04, 32'h0a54_8493);
    expect_hs(32'h08, 32'h0010_0093); expect_hs(32'h0C, 32'h0020_8113);
    expect_hs(32'h10, 32'h0031_0193); expect_hs(32'h14, 32'h0041_8213);
    expect_hs(32'h18, 32'h0052_0293); expect_hs(32'h1C, 32'h0085_2083);
    step();
    chk("c1_valid", {31'b0, dvalid}, 32'h1);
    chk("c1_instr", dinstr, 32'h2000_0537);
    chk("c1_dpc", dpc, 32'h0);
    step();
    chk("c2_instr", dinstr, 32'h0a54_8493);
    chk("c2_dpc", dpc, 32'h4);
    for (int i = 0; i < 7; i++) step();
    dready = 1'b0;
    chk("stream_retired", retired, 32'd8);

    // Backpressure: FIFO fills, pc holds at 0x8.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_pc_hold", pc, 32'h8);
    chk("bp_dpc", dpc, 32'h0);
    expect_hs(32'h00, 32'h2000_0537); expect_hs(32'h04, 32'h0a54_8493);
    expect_hs(32'h08, 32'h0010_0093);
    dready = 1'b1;
    step();
    chk("bp_c5_dpc", dpc, 32'h4);
    step();
    chk("bp_c6_dpc", dpc, 32'h8);
    step();
    dready = 1'b0;
    chk("bp_retired", retired, 32'd3);

    // Redirect while full.
    redirect = 1'b1; redirect_pc = 32'h1C;
    step();
    redirect = 1'b0;
    chk("rd_valid", {31'b0, dvalid}, 32'h0);
    chk("rd_pc", pc, 32'h1C);
    chk("rd_retired", retired, 32'd3);
    step();
    chk("rd_tgt_valid", {31'b0, dvalid}, 32'h1);
    chk("rd_tgt_instr", dinstr, 32'h0085_2083);
    chk("rd_tgt_dpc", dpc, 32'h1C);

    // Misaligned redirect coinciding with a handshake.
    dready = 1'b1; redirect = 1'b1; redirect_pc = 32'h1E;
    step();
    redirect = 1'b0;
    chk("mis_pc", pc, 32'h1C);
    chk("mis_valid", {31'b0, dvalid}, 32'h0);
    chk("mis_retired", retired, 32'd3);
    expect_hs(32'h1C, 32'h0085_2083); expect_hs(32'h20, imem(32'h20));
    step();
    chk("mis_dpc", dpc, 32'h1C);
    step();
    step();

    // Redirect to the top of the address space; PC wraps to zero.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    chk("wrap_pre_retired", retired, 32'd5);
    step();
    redirect = 1'b0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    expect_hs(32'hFFFF_FFFC, imem(32'hFFFF_FFFC)); expect_hs(32'h0, 32'h2000_0537);
    step();
    chk("wrap_dpc0", dpc, 32'hFFFF_FFFC);
    step();
    chk("wrap_dpc1", dpc, 32'h0);
    step();
    dready = 1'b0;
    chk("wrap_retired", retired, 32'd7);
    chk("wrap_partial_valid", {31'b0, dvalid}, 32'h1);

    // Reset mid-stream with the FIFO partly full.
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_valid", {31'b0, dvalid}, 32'h0);
    chk("mrst_retired", retired, 32'h0);
    dready = 1'b1;
    expect_hs(32'h00, 32'h2000_0537); expect_hs(32'h04, 32'h0a54_8493);
    expect_hs(32'h08, 32'h0010_0093);
    for (int i = 0; i < 4; i++) step();
    dready = 1'b0;
    chk("mrst_resume_retired", retired, 32'd3);
    step();
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
